weight_serializer: RTL and testbench

WEIGHT_SERIALIZER -- requirements
Module: weight_serializer

---
 rtl/wser_pkg.sv | 11 +
 rtl/weight_serializer.sv | 91 +++++++++
 tb/tb_weight_serializer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/wser_pkg.sv
// rtl/wser_pkg.sv - shared state type and constants for the weight serializer
package wser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int MAX_PREC = 8;

endpackage

// File: rtl/weight_serializer.sv
// rtl/weight_serializer.sv - parallel weight word to downstream bit-FIFO serializer
// Optional WSER_MSB_FIRST_EN: emit MSB first (bit P-1 down to 0) instead of LSB first.
module weight_serializer
  import wser_pkg::*;
#(
  parameter int DATA_W = MAX_PREC,
  parameter int PREC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PREC_W-1:0] precision,
  input  logic              full,
  output logic              wr_en,
  output logic              din,
  output logic              last,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] shift_word;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  prec_q;
  logic [CNT_W-1:0]  eff_prec;
  logic              accept;

  // Zero or oversized precision means "the whole word".
  always_comb begin
    eff_prec = CNT_W'(DATA_W);
    if (precision != '0 && 32'(precision) <= DATA_W) begin
      eff_prec = CNT_W'(precision);
    end
  end

`ifdef WSER_MSB_FIRST_EN
  // Left-justify bit P-1 so the top of the register is always the next bit.
  assign load_word  = in_data << (CNT_W'(DATA_W) - eff_prec);
  assign shift_word = sreg << 1;
  assign din        = busy & sreg[DATA_W-1];
`else
  assign load_word  = in_data;
  assign shift_word = sreg >> 1;
  assign din        = busy & sreg[0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state == SHIFT);
    last      = busy && (cnt == prec_q - CNT_W'(1));
    wr_en     = busy && !full;
    in_ready  = !busy || (last && !full);
    accept    = in_valid && in_ready;
    if (accept) begin
      state_nxt = SHIFT;
    end else if (wr_en && last) begin
      state_nxt = IDLE;
    end
  end

  // While full is high nothing moves, so din/last/cnt hold by construction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg   <= '0;
      cnt    <= '0;
      prec_q <= '0;
    end else if (accept) begin
      sreg   <= load_word;
      cnt    <= '0;
      prec_q <= eff_prec;
    end else if (wr_en) begin
      sreg   <= shift_word;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_weight_serializer.sv
// tb/tb_weight_serializer.sv - self-checking bench for weight_serializer against a bit-queue reference model
module tb_weight_serializer;

  localparam int DATA_W = 8;
  localparam int PREC_W = 4;
`ifdef WSER_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PREC_W-1:0] precision;
  logic              full;
  logic              wr_en;
  logic              din;
  logic              last;
  logic              busy;

  weight_serializer #(.DATA_W(DATA_W), .PREC_W(PREC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .precision(precision), .full(full),
    .wr_en(wr_en), .din(din), .last(last), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit rnd = 1'b0;

  bit got_bits[$];
  bit got_last[$];
  bit got_rdy[$];
  int got_cyc[$];
  bit exp_bits[$];
  bit exp_last[$];

  always @(posedge clk) cyc <= cyc + 1;

  // A write happens at the next rising edge when wr_en is high at the falling edge.
  always @(negedge clk) begin
    if (rst && wr_en) begin
      got_bits.push_back(din);
      got_last.push_back(last);
      got_rdy.push_back(in_ready);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(logic [DATA_W-1:0] d, int p);
    int e;
    e = (p == 0 || p > DATA_W) ? DATA_W : p;
    for (int i = 0; i < e; i++) begin
      exp_bits.push_back(MSB ? d[e-1-i] : d[i]);
      exp_last.push_back(i == e - 1);
    end
  endtask

  task automatic rand_full();
    if (rnd) full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic offer(logic [DATA_W-1:0] d, logic [PREC_W-1:0] p);
    int n = 0;
    in_data = d; precision = p; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; rand_full(); #1; n++;
    end
    check("offer_wait", 32'(n < 200), 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    in_data = DATA_W'($urandom);
    rand_full();
    expect_word(d, int'(p));
  endtask

  task automatic drain();
    int n = 0;
    #1;
    while (busy && n < 500) begin
      @(posedge clk); #1; rand_full(); #1; n++;
    end
    full = 1'b0;
    #1;
    check("drain_wait", 32'(n < 500), 1);
    check("idle_busy", 32'(busy), 0);
    check("idle_wr_en", 32'(wr_en), 0);
  endtask

  task automatic compare_stream(string tag, bit check_gap);
    int n;
    check({tag, "_count"}, got_bits.size(), exp_bits.size());
    n = (got_bits.size() < exp_bits.size()) ? got_bits.size() : exp_bits.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_bit%0d", tag, i), 32'(got_bits[i]), 32'(exp_bits[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(exp_last[i]));
      if (got_last[i]) check($sformatf("%s_rdy%0d", tag, i), 32'(got_rdy[i]), 1);
      if (check_gap && i > 0) check($sformatf("%s_gap%0d", tag, i), got_cyc[i] - got_cyc[i-1], 1);
    end
    got_bits.delete(); got_last.delete(); got_rdy.delete(); got_cyc.delete();
    exp_bits.delete(); exp_last.delete();
  endtask

  initial begin
    logic [DATA_W-1:0] held;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; precision = '0; full = 1'b0;

    // Reset behaviour
    @(posedge clk); #1;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_last", 32'(last), 0);
    check("rst_din", 32'(din), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);

    // Single word, precision 4
    offer(8'hA5, 4'd4);
    drain();
    check("a5_first_lat", got_cyc.size() > 0 ? got_cyc[0] : -1, acc_cyc);
    compare_stream("a5", 1'b1);

    // Back-to-back words, no gap
    offer(8'h0F, 4'd4);
    offer(8'hF0, 4'd4);
    drain();
    compare_stream("b2b", 1'b1);

    // Backpressure: full for 3 cycles after the 2nd bit
    offer(8'h96, 4'd8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    full = 1'b1;
    #1;
    held = {7'd0, din};
    repeat (3) begin
      check("stall_wr_en", 32'(wr_en), 0);
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_din", 32'(din), 32'(held));
      @(posedge clk); #1;
    end
    check("stall_cnt", got_bits.size(), 2);
    full = 1'b0;
    drain();
    compare_stream("stall", 1'b0);

    // Precision clamping
    offer(8'hFF, 4'd0);
    drain();
    check("prec0_writes", got_bits.size(), 8);
    compare_stream("prec0", 1'b1);
    offer(8'hFF, 4'd12);
    drain();
    check("prec12_writes", got_bits.size(), 8);
    compare_stream("prec12", 1'b1);

    // Reset after the 3rd bit of a full-width word
    offer(8'h6B, 4'd8);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_din", 32'(din), 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_rst_quiet", 32'(wr_en), 0);
    while (exp_bits.size() > 3) begin
      void'(exp_bits.pop_back());
      void'(exp_last.pop_back());
    end
    compare_stream("mid_rst", 1'b0);
    offer(8'h3C, 4'd8);
    drain();
    compare_stream("post_rst", 1'b1);

    // Randomized words, precisions and backpressure
    rnd = 1'b1;
    for (int w = 0; w < 30; w++) begin
      offer(DATA_W'($urandom), PREC_W'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1; rand_full();
        end
      end
    end
    drain();
    rnd = 1'b0;
    compare_stream("rand", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
